// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the main-memory port arbiter
//   slave modport  : arbiter side (takes requests and memory read data, drives strobes, status and done)
//   master modport : requesters plus memory side (drives requests, mem_data_in and mem_ready)
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  m0_req, m0_we, m0_done, m1_req, m1_we, m1_done;
  logic [ADDR_WIDTH-1:0] m0_addr, m1_addr, mem_addr_out;
  logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata, mem_data_out, mem_data_in;
  logic                  mem_read_en, mem_write_en, mem_ready, owner, busy, timeout_err;
  logic [15:0]           stat_m0_grants, stat_m1_grants;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_data_in, mem_ready,
    output m0_rdata, m0_done, m1_rdata, m1_done, mem_addr_out, mem_data_out, mem_read_en, mem_write_en,
           owner, busy, timeout_err, stat_m0_grants, stat_m1_grants
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_data_in, mem_ready,
    input  m0_rdata, m0_done, m1_rdata, m1_done, mem_addr_out, mem_data_out, mem_read_en, mem_write_en,
           owner, busy, timeout_err, stat_m0_grants, stat_m1_grants
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter and sequencer for the single main-memory port
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : mem_port_arbiter_if.slave -- m0_*/m1_* requester handshakes, mem_* memory port,
//           owner/busy/timeout_err status, stat_m0_grants/stat_m1_grants grant counters
//   Define MEM_ARB_STATS_EN to build the saturating grant counters; otherwise they are tied to 0.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                state;
  logic                  last_grant, we_q, gnt, grant, sel_we, expired;
  logic [15:0]           wd;
  logic [16:0]           wd_next;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, rd_val;
  // A tie goes to whoever was not served last; a lone request simply wins.
  assign gnt       = bus.m0_req && bus.m1_req ? !last_grant : bus.m1_req;
  assign grant     = state == IDLE && (bus.m0_req || bus.m1_req);
  assign sel_we    = gnt ? bus.m1_we : bus.m0_we;
  assign sel_addr  = gnt ? bus.m1_addr : bus.m0_addr;
  assign sel_wdata = gnt ? bus.m1_wdata : bus.m0_wdata;
  // The watchdog gives up on the cycle its count would reach TIMEOUT_CYCLES, so WAIT never exceeds that length.
  assign wd_next   = {1'b0, wd} + 17'd1;
  assign expired   = wd_next == 17'(TIMEOUT_CYCLES);
  assign rd_val    = bus.mem_ready ? bus.mem_data_in : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      we_q             <= 1'b0;
      wd               <= '0;
      bus.owner        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.mem_addr_out <= '0;
      bus.mem_data_out <= '0;
      bus.mem_read_en  <= 1'b0;
      bus.mem_write_en <= 1'b0;
      bus.m0_rdata     <= '0;
      bus.m1_rdata     <= '0;
      bus.m0_done      <= 1'b0;
      bus.m1_done      <= 1'b0;
    end else begin
      bus.m0_done      <= 1'b0;
      bus.m1_done      <= 1'b0;
      bus.mem_read_en  <= 1'b0;
      bus.mem_write_en <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          state            <= ISSUE;
          bus.busy         <= 1'b1;
          bus.owner        <= gnt;
          we_q             <= sel_we;
          bus.mem_addr_out <= sel_addr;
          bus.mem_data_out <= sel_wdata;
          bus.mem_read_en  <= !sel_we;
          bus.mem_write_en <= sel_we;
        end
        ISSUE: begin
          state <= WAIT;
          wd    <= '0;
        end
        WAIT: if (bus.mem_ready || expired) begin
          state       <= DONE;
          bus.m0_done <= !bus.owner;
          bus.m1_done <= bus.owner;
          if (!bus.mem_ready) bus.timeout_err <= 1'b1;
          if (!we_q && bus.owner) bus.m1_rdata <= rd_val;
          if (!we_q && !bus.owner) bus.m0_rdata <= rd_val;
        end else wd <= wd_next[15:0];
        DONE: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          last_grant <= bus.owner;
        end
      endcase
    end
  end
`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.stat_m0_grants <= '0;
      bus.stat_m1_grants <= '0;
    end else if (grant) begin
      if (!gnt && ~&bus.stat_m0_grants) bus.stat_m0_grants <= bus.stat_m0_grants + 16'd1;
      if (gnt && ~&bus.stat_m1_grants) bus.stat_m1_grants <= bus.stat_m1_grants + 16'd1;
    end
  end
`else
  assign bus.stat_m0_grants = '0;
  assign bus.stat_m1_grants = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter (TIMEOUT_CYCLES = 8)
module tb_mem_port_arbiter;
  typedef struct {
    logic        who;
    logic [31:0] rdata;
  } sb_t;
  logic        clk = 1'b0;
  logic        reset;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  sb_t         sb[$];
  int          done_t[$];
  sb_t         mon_e;
  logic [31:0] exp_rd[2];
  logic [31:0] rdv[4];
  bit          found;
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();
  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic who, input logic we, input logic [31:0] rd);
    sb_t e;
    if (!we) exp_rd[who] = rd;
    e.who   = who;
    e.rdata = exp_rd[who];
    sb.push_back(e);
  endtask
  task automatic rand_inputs();
    bus.m0_req      = 1'($urandom);
    bus.m0_we       = 1'($urandom);
    bus.m0_addr     = 16'($urandom);
    bus.m0_wdata    = $urandom;
    bus.m1_req      = 1'($urandom);
    bus.m1_we       = 1'($urandom);
    bus.m1_addr     = 16'($urandom);
    bus.m1_wdata    = $urandom;
    bus.mem_ready   = 1'($urandom);
    bus.mem_data_in = $urandom;
  endtask
  // Acts as the memory: finds the ISSUE cycle, then raises mem_ready in WAIT cycle d (never if d < 0).
  task automatic serve(input logic who, input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input int d, input logic [31:0] rdval, input int waits);
    bit          seen = 0;
    int          k = 0;
    logic [15:0] ia;
    logic [31:0] idat;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = bus.mem_read_en || bus.mem_write_en;
    end
    chk("issue_seen", 64'(seen), 64'd1);
    ia   = bus.mem_addr_out;
    idat = bus.mem_data_out;
    chk("issue_owner", 64'(bus.owner), 64'(who));
    chk("issue_strobes", 64'({bus.mem_read_en, bus.mem_write_en}), we ? 64'd1 : 64'd2);
    chk("issue_addr", 64'(ia), 64'(addr));
    if (we) chk("issue_wdata", 64'(idat), 64'(wdata));
    chk("issue_busy", 64'(bus.busy), 64'd1);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      bus.mem_ready   = 1'b0;
      bus.mem_data_in = $urandom;
      seen = bus.m0_done || bus.m1_done;
      if (!seen) begin
        chk("wait_strobes", 64'({bus.mem_read_en, bus.mem_write_en}), 64'd0);
        chk("wait_addr_held", 64'(bus.mem_addr_out), 64'(ia));
        chk("wait_data_held", 64'(bus.mem_data_out), 64'(idat));
        if (k == d) begin
          bus.mem_ready   = 1'b1;
          bus.mem_data_in = rdval;
        end
        k++;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("wait_len", 64'(k), 64'(waits));
  endtask
  // Monitor: strobe exclusivity every cycle, and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    chk("strobe_overlap", 64'(bus.mem_read_en & bus.mem_write_en), 64'd0);
    if (bus.m0_done || bus.m1_done) begin
      done_t.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_done", 64'({bus.m1_done, bus.m0_done}), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("done_who", 64'({bus.m1_done, bus.m0_done}), mon_e.who ? 64'd2 : 64'd1);
        chk("done_rdata", 64'(mon_e.who ? bus.m1_rdata : bus.m0_rdata), 64'(mon_e.rdata));
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end
  initial begin
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    reset = 1'b0;
    rand_inputs();
    repeat (3) begin
      tick();
      rand_inputs();
    end
    chk("rst_rd_en", 64'(bus.mem_read_en), 64'd0);
    chk("rst_wr_en", 64'(bus.mem_write_en), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr_out), 64'd0);
    chk("rst_data", 64'(bus.mem_data_out), 64'd0);
    chk("rst_m0_rdata", 64'(bus.m0_rdata), 64'd0);
    chk("rst_m1_rdata", 64'(bus.m1_rdata), 64'd0);
    chk("rst_done", 64'({bus.m1_done, bus.m0_done}), 64'd0);
    chk("rst_owner", 64'(bus.owner), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    chk("rst_stats", 64'({bus.stat_m1_grants, bus.stat_m0_grants}), 64'd0);
    // Both requesters held from reset release: m0 first, then strict alternation, 4 cycles per access.
    rdv[0] = 32'hA0A0_0001;
    rdv[1] = 32'hB0B0_0001;
    rdv[2] = 32'hA0A0_0002;
    rdv[3] = 32'hB0B0_0002;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0010;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0020;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1'(i % 2), 1'b0, rdv[i]);
    done_t.delete();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(1'(i % 2), 1'b0, i % 2 ? 16'h0020 : 16'h0010, 32'h0, 0, rdv[i], 1);
      if (i == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
    end
    tick();
    chk("rr_sb_empty", 64'(sb.size()), 64'd0);
    chk("rr_done_count", 64'(done_t.size()), 64'd4);
    for (int i = 1; i < done_t.size(); i++) chk("rr_done_spacing", 64'(done_t[i] - done_t[i-1]), 64'd4);
    // m0 read at 0x1234, ready in the third WAIT cycle.
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h1234; bus.m0_wdata = 32'h0;
    push(1'b0, 1'b0, 32'hCAFE_F00D);
    serve(1'b0, 1'b0, 16'h1234, 32'h0, 2, 32'hCAFE_F00D, 3);
    bus.m0_req = 1'b0;
    tick();
    tick();
    chk("rd_sb_empty", 64'(sb.size()), 64'd0);
    chk("rd_m0_rdata", 64'(bus.m0_rdata), 64'hCAFE_F00D);
    chk("rd_busy_idle", 64'(bus.busy), 64'd0);
    // m1 write at 0x00FF; m1_rdata must keep the last read value.
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h00FF; bus.m1_wdata = 32'h1122_3344;
    push(1'b1, 1'b1, 32'h0);
    serve(1'b1, 1'b1, 16'h00FF, 32'h1122_3344, 1, 32'hDEAD_DEAD, 2);
    bus.m1_req = 1'b0;
    tick();
    tick();
    chk("wr_sb_empty", 64'(sb.size()), 64'd0);
    chk("wr_m1_rdata", 64'(bus.m1_rdata), 64'hB0B0_0002);
    chk("wr_timeout_err", 64'(bus.timeout_err), 64'd0);
    // m0 read that never sees mem_ready: 8 WAIT cycles, rdata forced to 0, sticky error.
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0BAD;
    push(1'b0, 1'b0, 32'h0);
    serve(1'b0, 1'b0, 16'h0BAD, 32'h0, -1, 32'h0, 8);
    bus.m0_req = 1'b0;
    tick();
    tick();
    chk("to_sb_empty", 64'(sb.size()), 64'd0);
    chk("to_m0_rdata", 64'(bus.m0_rdata), 64'd0);
    chk("to_timeout_err", 64'(bus.timeout_err), 64'd1);
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0042;
    push(1'b1, 1'b0, 32'h5A5A_5A5A);
    serve(1'b1, 1'b0, 16'h0042, 32'h0, 0, 32'h5A5A_5A5A, 1);
    bus.m1_req = 1'b0;
    tick();
    tick();
    chk("sticky_sb_empty", 64'(sb.size()), 64'd0);
    chk("sticky_timeout_err", 64'(bus.timeout_err), 64'd1);
    // Reset during WAIT of an m1 read: access abandoned, no done pulse.
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0077;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      found = bus.mem_read_en;
    end
    chk("mid_issue_seen", 64'(found), 64'd1);
    tick();
    tick();
    chk("mid_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    tick();
    chk("mid_busy", 64'(bus.busy), 64'd0);
    chk("mid_strobes", 64'({bus.mem_read_en, bus.mem_write_en}), 64'd0);
    chk("mid_m1_done", 64'(bus.m1_done), 64'd0);
    chk("mid_timeout_err", 64'(bus.timeout_err), 64'd0);
    chk("mid_m1_rdata", 64'(bus.m1_rdata), 64'd0);
    bus.m1_req = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    reset = 1'b1;
    tick();
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0078;
    push(1'b1, 1'b0, 32'h0BAD_BEEF);
    serve(1'b1, 1'b0, 16'h0078, 32'h0, 1, 32'h0BAD_BEEF, 2);
    bus.m1_req = 1'b0;
    tick();
    tick();
    chk("post_sb_empty", 64'(sb.size()), 64'd0);
    chk("post_m1_rdata", 64'(bus.m1_rdata), 64'h0BAD_BEEF);
    chk("post_m0_rdata", 64'(bus.m0_rdata), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single main-memory port.
- Requester 0 is the cache controller memory side. Requester 1 is a secondary master, e.g. a UART/debug DMA.
- Serialises one read or write at a time onto memory addr_in, data_in, read_enable and write_enable, and waits for memory ready.
- Returns read data and a done pulse to the owning requester. A watchdog terminates stalled accesses.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 16, address bus width.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before forced completion; legal range 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- m0_req  in  1  requester 0 access request; held until m0_done.
- m0_we  in  1  1=write, 0=read; stable while m0_req.
- m0_addr  in  ADDR_WIDTH  requester 0 address.
- m0_wdata  in  DATA_WIDTH  requester 0 write data.
- m0_rdata  out  DATA_WIDTH  requester 0 read data, registered.
- m0_done  out  1  one-cycle completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done  same as m0_*, for requester 1.
- mem_addr_out  out  ADDR_WIDTH  address to memory.
- mem_data_out  out  DATA_WIDTH  write data to memory.
- mem_read_en  out  1  read strobe.
- mem_write_en  out  1  write strobe.
- mem_data_in  in  DATA_WIDTH  read data from memory.
- mem_ready  in  1  memory access complete.
- owner  out  1  index of the requester currently being served; valid when busy.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset is synchronous, active-low.
  - All outputs go to 0 and state goes to IDLE.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - Watchdog counter is cleared.
  - A reset asserted mid-access abandons the access: no done pulse, strobes drop on the next edge.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant !last_grant.
  - On grant: latch owner, we, addr and wdata into internal registers, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_read_en = !we, mem_write_en = we.
  - mem_addr_out and mem_data_out driven from the latched values.
  - Watchdog cleared. mem_ready is ignored in this state. Next state WAIT.
- WAIT:
  - Strobes low; mem_addr_out and mem_data_out held stable.
  - mem_ready=1: if the access is a read, capture mem_data_in into the owner's rdata; go to DONE.
  - Otherwise increment the watchdog. When it would reach TIMEOUT_CYCLES, go to DONE with the error path:
    - owner rdata = 0 on a read;
    - timeout_err set to 1, sticky until reset.
  - WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
- DONE (1 cycle):
  - Owner's mN_done = 1.
  - last_grant updated to owner.
  - Next state IDLE.
- Requester rule: req must be low in the cycle after the done pulse. The DONE→IDLE cycle guarantees a requester that registers done is not re-granted.
- Latency: req first high in IDLE at cycle 0 → ISSUE in cycle 1 → WAIT from cycle 2 → done in the cycle after mem_ready is sampled. Minimum is 4 cycles, reached when mem_ready is high in the first WAIT cycle.
- mN_rdata holds its value until the next read completion for that requester; writes leave it unchanged.
- The request of the requester not being served is ignored until IDLE; it is never lost if held.
- No preemption; only one access is in flight at any time.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1. Neither requester waits more than one access.
- Memory side: mem_read_en and mem_write_en are never high together. Neither is high outside ISSUE.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds 16-bit registered outputs stat_m0_grants and stat_m1_grants.
  - Each increments on every grant to its requester, saturating at 0xFFFF.
  - Both clear on reset.
- Undefined: the ports exist but are tied to 0, and no counter logic is built.

Test Plan:
- Reset check: hold reset=0 for 3 clocks with random inputs → all outputs 0, busy=0; after release, first tie is granted to m0.
- m0 read at 0x1234, memory returns mem_ready 2 cycles into WAIT with 0xCAFEF00D:
  - mem_read_en high exactly 1 cycle with mem_addr_out=0x1234;
  - m0_done pulses once, m0_rdata=0xCAFEF00D;
  - m1_done stays 0.
- m1 write at 0x00FF, data 0x11223344: mem_write_en high 1 cycle, mem_data_out=0x11223344 held through WAIT, m1_done pulses, m1_rdata unchanged.
- Both requests held from reset release, mem_ready on first WAIT cycle: grant order m0,m1,m0,m1; each done 4 cycles apart in steady state; strobes never overlap.
- TIMEOUT_CYCLES=8, m0 read, mem_ready never asserted: done 8 WAIT cycles after ISSUE, m0_rdata=0, timeout_err=1 and stays 1 through a following normal access.
- Reset mid-access: reset asserted in WAIT of an m1 read → no m1_done; busy and strobes are 0 after the edge; the next access completes normally.
